// File: rtl/div_seq_pkg.sv
// Shared ALU divide definitions: operation codes, FSM states, request payload and decode helpers.
package div_seq_pkg;

  localparam int unsigned XLEN_W = 64;
  localparam int unsigned HALF_W = 32;
  localparam int unsigned CNT_W  = 7;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned ST_W   = 2;

  localparam logic [OP_W-1:0] OP_DIVW  = 4'd0;
  localparam logic [OP_W-1:0] OP_REMW  = 4'd1;
  localparam logic [OP_W-1:0] OP_DIVU  = 4'd2;
  localparam logic [OP_W-1:0] OP_DIVUW = 4'd3;
  localparam logic [OP_W-1:0] OP_REMU  = 4'd4;
  localparam logic [OP_W-1:0] OP_REMUW = 4'd5;
  localparam logic [OP_W-1:0] OP_DIV   = 4'd6;
  localparam logic [OP_W-1:0] OP_REM   = 4'd7;

  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_PREP = 2'd1;
  localparam logic [ST_W-1:0] ST_BUSY = 2'd2;
  localparam logic [ST_W-1:0] ST_DONE = 2'd3;

  typedef struct packed {
    logic [OP_W-1:0]   control;
    logic [XLEN_W-1:0] src1;
    logic [XLEN_W-1:0] src2;
  } div_req_t;

  function automatic logic is_w_op(input logic [OP_W-1:0] op);
    return (op == OP_DIVW) || (op == OP_REMW) || (op == OP_DIVUW) || (op == OP_REMUW);
  endfunction

  function automatic logic is_signed_op(input logic [OP_W-1:0] op);
    return (op == OP_DIVW) || (op == OP_REMW) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_rem_op(input logic [OP_W-1:0] op);
    return (op == OP_REMW) || (op == OP_REMU) || (op == OP_REMUW) || (op == OP_REM);
  endfunction

  function automatic logic [XLEN_W-1:0] sext32(input logic [HALF_W-1:0] v);
    return {{HALF_W{v[HALF_W-1]}}, v};
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift the next dividend bit in, trial-subtract the divisor.
module div_step
  import div_seq_pkg::*;
(
  input  logic [XLEN_W-1:0] rem,
  input  logic [XLEN_W-1:0] quo,
  input  logic [XLEN_W-1:0] dvs,
  output logic [XLEN_W-1:0] next_rem,
  output logic [XLEN_W-1:0] next_quo
);

  logic [XLEN_W:0] rem_sh;
  logic [XLEN_W:0] diff;

  // The quotient register doubles as the dividend shifter; quotient bits enter at the LSB.
  always_comb begin
    rem_sh = {rem, quo[XLEN_W-1]};
    diff   = rem_sh - {1'b0, dvs};
    if (!diff[XLEN_W]) begin
      next_rem = diff[XLEN_W-1:0];
      next_quo = {quo[XLEN_W-2:0], 1'b1};
    end else begin
      next_rem = rem_sh[XLEN_W-1:0];
      next_quo = {quo[XLEN_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_seq.sv
// Sequential radix-2 restoring divider for the RV64M divide/remainder ops.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [3:0]      control,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  logic [ST_W-1:0]   state_q, state_n;
  div_req_t          req_q, req_n;
  logic [XLEN_W-1:0] rem_q, rem_n;
  logic [XLEN_W-1:0] quo_q, quo_n;
  logic [XLEN_W-1:0] dvs_q, dvs_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic              w_q, w_n;
  logic              rsel_q, rsel_n;
  logic              qneg_q, qneg_n;
  logic              rneg_q, rneg_n;
  logic              bad_q, bad_n;
  logic              out_valid_q, out_valid_n;
  logic [XLEN_W-1:0] result_q, result_n;
  logic              busy_q;

  logic [XLEN_W-1:0] step_rem, step_quo;

  logic [OP_W-1:0]   op_c;
  logic              bad_c, w_c, sgn_c, rsel_c;
  logic [XLEN_W-1:0] a_ext, b_ext, a_mag, b_mag;
  logic              a_neg, b_neg, dvs_zero, ovf_c;
  logic [XLEN_W-1:0] fin_q, fin_r, fin_res;

  div_step u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .dvs      (dvs_q),
    .next_rem (step_rem),
    .next_quo (step_quo)
  );

  // Operand decode from the latched request (consumed in PREP).
  always_comb begin
    bad_c  = (req_q.control > OP_REM);
    op_c   = bad_c ? OP_DIVW : req_q.control;
    w_c    = is_w_op(op_c);
    sgn_c  = is_signed_op(op_c);
    rsel_c = is_rem_op(op_c);
    if (w_c) begin
      a_ext = sgn_c ? sext32(req_q.src1[HALF_W-1:0]) : {{HALF_W{1'b0}}, req_q.src1[HALF_W-1:0]};
      b_ext = sgn_c ? sext32(req_q.src2[HALF_W-1:0]) : {{HALF_W{1'b0}}, req_q.src2[HALF_W-1:0]};
    end else begin
      a_ext = req_q.src1;
      b_ext = req_q.src2;
    end
    a_neg    = sgn_c & a_ext[XLEN_W-1];
    b_neg    = sgn_c & b_ext[XLEN_W-1];
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
    dvs_zero = (b_ext == '0);
    ovf_c    = sgn_c && (b_ext == '1) &&
               (a_ext == (w_c ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
  end

  // Sign correction, result select and W-op sign extension.
  always_comb begin
    fin_q   = qneg_q ? -quo_q : quo_q;
    fin_r   = rneg_q ? -rem_q : rem_q;
    fin_res = rsel_q ? fin_r : fin_q;
    if (w_q) fin_res = sext32(fin_res[HALF_W-1:0]);
    if (bad_q) fin_res = '0;
  end

  // Next-state and next-register logic.
  always_comb begin
    state_n     = state_q;
    req_n       = req_q;
    rem_n       = rem_q;
    quo_n       = quo_q;
    dvs_n       = dvs_q;
    cnt_n       = cnt_q;
    w_n         = w_q;
    rsel_n      = rsel_q;
    qneg_n      = qneg_q;
    rneg_n      = rneg_q;
    bad_n       = bad_q;
    out_valid_n = out_valid_q;
    result_n    = result_q;

    if (flush) begin
      state_n     = ST_IDLE;
      out_valid_n = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            req_n   = '{control: control, src1: src1, src2: src2};
            state_n = ST_PREP;
          end
        end
        ST_PREP: begin
          w_n    = w_c;
          rsel_n = rsel_c;
          bad_n  = bad_c;
          if (dvs_zero || ovf_c) begin
            quo_n   = dvs_zero ? '1 : a_ext;
            rem_n   = dvs_zero ? a_ext : '0;
            qneg_n  = 1'b0;
            rneg_n  = 1'b0;
            cnt_n   = '0;
            state_n = ST_DONE;
          end else begin
            rem_n   = '0;
            quo_n   = w_c ? {a_mag[HALF_W-1:0], {HALF_W{1'b0}}} : a_mag;
            dvs_n   = b_mag;
            qneg_n  = a_neg ^ b_neg;
            rneg_n  = a_neg;
            cnt_n   = w_c ? CNT_W'(HALF_W) : CNT_W'(XLEN_W);
            state_n = ST_BUSY;
          end
        end
        ST_BUSY: begin
          rem_n = step_rem;
          quo_n = step_quo;
          cnt_n = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_n = ST_DONE;
        end
        ST_DONE: begin
          // First DONE cycle finalises the result; it is then held until taken.
          if (!out_valid_q) begin
            result_n    = fin_res;
            out_valid_n = 1'b1;
          end else if (out_ready) begin
            out_valid_n = 1'b0;
            state_n     = ST_IDLE;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      w_q         <= 1'b0;
      rsel_q      <= 1'b0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      bad_q       <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_n;
      req_q       <= req_n;
      rem_q       <= rem_n;
      quo_q       <= quo_n;
      dvs_q       <= dvs_n;
      cnt_q       <= cnt_n;
      w_q         <= w_n;
      rsel_q      <= rsel_n;
      qneg_q      <= qneg_n;
      rneg_q      <= rneg_n;
      bad_q       <= bad_n;
      out_valid_q <= out_valid_n;
      result_q    <= result_n;
      busy_q      <= (state_n != ST_IDLE);
    end
  end

  assign in_ready  = rst_n && (state_q == ST_IDLE) && !flush;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed vector table, randomized ops against a reference model, corner sequences.
module tb_div_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] src1;
  logic [63:0] src2;
  logic [3:0]  control;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        busy;

  int checks = 0;
  int errors = 0;

  div_seq #(.XLEN(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .src1      (src1),
    .src2      (src2),
    .control   (control),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]  c;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Reference result from the RISC-V M-extension definition.
  function automatic logic [63:0] ref_res(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b);
    logic signed [31:0] sa, sb;
    logic signed [63:0] la, lb;
    logic [31:0] ua, ub, r32;
    logic [63:0] r;
    sa = a[31:0]; sb = b[31:0]; ua = a[31:0]; ub = b[31:0];
    la = a; lb = b;
    r32 = '0; r = '0;
    case (c)
      4'd0: begin
        if (ub == 0) r32 = 32'hFFFF_FFFF;
        else if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) r32 = ua;
        else r32 = sa / sb;
        r = {{32{r32[31]}}, r32};
      end
      4'd1: begin
        if (ub == 0) r32 = ua;
        else if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) r32 = 32'h0;
        else r32 = sa % sb;
        r = {{32{r32[31]}}, r32};
      end
      4'd2: r = (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
      4'd3: begin
        r32 = (ub == 0) ? 32'hFFFF_FFFF : ua / ub;
        r = {{32{r32[31]}}, r32};
      end
      4'd4: r = (b == 0) ? a : a % b;
      4'd5: begin
        r32 = (ub == 0) ? ua : ua % ub;
        r = {{32{r32[31]}}, r32};
      end
      4'd6: begin
        if (lb == 0) r = 64'hFFFF_FFFF_FFFF_FFFF;
        else if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) r = a;
        else r = la / lb;
      end
      4'd7: begin
        if (lb == 0) r = a;
        else if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) r = 64'h0;
        else r = la % lb;
      end
      default: r = 64'h0;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b);
    logic [3:0] cc;
    logic w, s, zero, ovf;
    cc   = (c > 4'd7) ? 4'd0 : c;
    w    = (cc == 4'd0) || (cc == 4'd1) || (cc == 4'd3) || (cc == 4'd5);
    s    = (cc == 4'd0) || (cc == 4'd1) || (cc == 4'd6) || (cc == 4'd7);
    zero = w ? (b[31:0] == 32'h0) : (b == 64'h0);
    ovf  = s && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                   : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF));
    if (zero || ovf) return 2;
    return w ? 34 : 66;
  endfunction

  task automatic start_op(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    control  = c;
    src1     = a;
    src2     = b;
    in_valid = 1'b1;
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("busy_after_accept", 64'(busy), 64'd1);
  endtask

  task automatic wait_result(output logic [63:0] res, output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = result;
  endtask

  task automatic retire();
    @(negedge clk);
    chk("in_ready_done", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("out_valid_retired", 64'(out_valid), 64'd0);
    chk("busy_retired", 64'(busy), 64'd0);
  endtask

  task automatic run_check(input string name, input logic [3:0] c, input logic [63:0] a,
                           input logic [63:0] b, input logic [63:0] exp, input int exp_lat);
    logic [63:0] res;
    int lat;
    start_op(c, a, b);
    wait_result(res, lat);
    chk({name, "_result"}, res, exp);
    chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
    retire();
  endtask

  initial begin
    logic [63:0] res, ra, rb, held;
    logic [3:0]  rc;
    int lat, seen;

    rst_n = 1'b0; in_valid = 1'b0; src1 = '0; src2 = '0; control = '0;
    flush = 1'b0; out_ready = 1'b0;

    vecs[0]  = '{4'd2, 64'd100, 64'd7, 64'd14, 66};
    vecs[1]  = '{4'd4, 64'd100, 64'd7, 64'd2, 66};
    vecs[2]  = '{4'd0, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34};
    vecs[3]  = '{4'd1, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34};
    vecs[4]  = '{4'd6, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2};
    vecs[5]  = '{4'd7, 64'd5, 64'd0, 64'd5, 2};
    vecs[6]  = '{4'd6, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 2};
    vecs[7]  = '{4'd1, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 2};
    vecs[8]  = '{4'd3, 64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 34};
    vecs[9]  = '{4'd5, 64'hFFFF_FFF0, 64'd7, 64'd2, 34};
    vecs[10] = '{4'd9, 64'd10, 64'd3, 64'd0, 34};
    vecs[11] = '{4'd6, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 66};
    vecs[12] = '{4'd7, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 66};
    vecs[13] = '{4'd0, 64'hDEAD_BEEF_0000_0064, 64'h1234_5678_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 34};

    // Reset values
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_result", result, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_reset", 64'(in_ready), 64'd1);

    for (int i = 0; i < 14; i++) begin
      run_check($sformatf("vec%0d", i), vecs[i].c, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
    end

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      rc = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: rb = 64'h0;
        1: rb = 64'($urandom_range(1, 20));
        2: begin rb = 64'hFFFF_FFFF_FFFF_FFFF; if ($urandom_range(0, 1) == 1) ra = 64'h8000_0000_0000_0000; end
        3: rb = {32'h0, $urandom};
        default: ;
      endcase
      run_check($sformatf("rnd%0d", i), rc, ra, rb, ref_res(rc, ra, rb), ref_lat(rc, ra, rb));
    end

    // Result held while writeback stalls; no overlap on the retire edge
    start_op(4'd3, 64'hFFFF_FFFF, 64'd1);
    wait_result(held, lat);
    chk("hold_result", held, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("hold_latency", 64'(lat), 64'd34);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      chk($sformatf("hold_in_ready_%0d", k), 64'(in_ready), 64'd0);
      chk($sformatf("hold_stable_%0d", k), result, 64'hFFFF_FFFF_FFFF_FFFF);
      chk($sformatf("hold_valid_%0d", k), 64'(out_valid), 64'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    src1 = 64'd9; src2 = 64'd3; control = 4'd2;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("no_overlap_busy", 64'(busy), 64'd0);
    chk("no_overlap_valid", 64'(out_valid), 64'd0);

    // Flush mid-BUSY
    start_op(4'd2, 64'd100, 64'd7);
    repeat (11) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    out_ready = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    seen = 0;
    for (int k = 0; k < 70; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("flush_no_pulse", 64'(seen), 64'd0);
    run_check("after_flush", 4'd2, 64'd100, 64'd7, 64'd14, 66);

    // Reset mid-BUSY
    start_op(4'd6, 64'd1000, 64'd3);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstmid_out_valid", 64'(out_valid), 64'd0);
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_result", result, 64'd0);
    chk("rstmid_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rstmid_in_ready_release", 64'(in_ready), 64'd1);
    seen = 0;
    for (int k = 0; k < 70; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("rstmid_no_pulse", 64'(seen), 64'd0);
    run_check("after_reset", 4'd7, 64'd1000, 64'd3, 64'd1, 66);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
